hs32_intctl: RTL
================

// Module: hs32_intctl
// PURPOSE
// - Interrupt controller directly outside hs32_cpu; drives its intrq/handler/vec/nmi inputs, consumes iack.
// - Synchronises 24 peripheral IRQ lines plus one NMI pin and latches rising edges as pending.
// - Arbitrates by fixed priority and presents one request at a time with its ISR address.
// - ISR addresses and the enable mask are set through a small valid/ready register port.
// PARAMETERS
// - NLINES   24  number of maskable IRQ lines (1..24); line i maps to vector i+1
// - SYNC_FF  2   synchroniser depth on irq/nmi_pin (>=2)
// PORTS
// - i_clk      in   1   clock
// - reset      in   1   asynchronous, active-high reset
// - irq        in   24  peripheral interrupt lines, asynchronous, rising-edge triggered
// - nmi_pin    in   1   non-maskable interrupt, asynchronous, rising-edge triggered
// - intrq      out  1   request to CPU
// - handler    out  32  ISR address for the presented vector
// - vec        out  5   presented vector (0 = NMI, 1..24 = irq[0..23])
// - nmi        out  1   presented request is the NMI
// - iack       in   1   CPU acknowledge, one-cycle pulse
// - cfg_addr   in   5   register select: 0..24 handler table, 25 mask, 26 pending
// - cfg_rw     in   1   1 = write, 0 = read
// - cfg_din    in   32  write data
// - cfg_dout   out  32  read data
// - cfg_valid  in   1   register access request
// - cfg_ready  out  1   access complete
// BEHAVIOUR
// - Reset (async, any state): intrq=0, nmi=0, vec=0, handler=0, cfg_dout=0, cfg_ready=0.
//   Reset also clears the handler table, mask, pending, synchronisers and edge detectors, and sets FSM=IDLE.
// - Edge path: SYNC_FF-stage sync, then a registered previous value. Rise = sync & ~prev.
// - Edge-to-pending latency (SYNC_FF=2): line high before edge k -> pending set at edge k+2. Pulses <1 clk may be lost.
// - pending[24:0]: bit 0 = NMI, bit n = irq[n-1]. Sticky, set by a rise regardless of mask.
// - Eligible = pending & {mask[23:0],1'b1}. The NMI bit ignores mask. Winner = lowest eligible index.
// - FSM IDLE: if any eligible, go to REQ on the next edge.
//   On entry, latch vec=winner, handler=table[winner], nmi=(winner==0), and raise intrq.
// - FSM REQ: intrq, vec, handler and nmi are held stable until iack.
//   No preemption: a higher-priority arrival waits. A mask clear does not withdraw the request.
// - REQ on iack: clear pending[vec], drop intrq, go to GAP.
// - FSM GAP: one cycle with intrq=0, then IDLE. Next request at earliest 2 clks after iack.
// - iack seen in IDLE/GAP is ignored.
// - Same-cycle set and clear on a pending bit (rise vs iack clear, or rise vs W1C): set wins, so the event is kept.
// - Register port: cfg_valid sampled at edge k -> cfg_ready=1 for exactly the cycle after k, with cfg_dout valid then.
//   cfg_ready is low otherwise, including cycle k+1 when cfg_valid is held (one access per 2 clks).
//   cfg_dout holds its last value when not ready.
// - Writes: addr 0..24 write the handler table. Addr 25 = mask, bits[23:0] used, [31:24] read 0.
//   Addr 26 = pending, write-1-to-clear bits[24:0]; bit 0 (NMI) is clearable too.
// - Reads: addr 25 returns mask, addr 26 returns {7'b0, pending}, addr 27..31 return 0 and writes there are dropped.
// - handler is latched at REQ entry, so a table write during REQ does not change the presented handler.
// - W1C of the presented vector's bit during REQ: request stays until iack, and iack clear is then a no-op.
// - Lines >= NLINES: pending, mask and priority bits tie to 0.
// TESTING
// - Reset with irq=0, mask=0: write table[3]=0x0000_1000 and mask=0x4.
//   Pulse irq[2] 3 clks: intrq rises at edge k+3, vec=3, handler=0x1000, nmi=0.
//   Then iack: pending=0, intrq low, and stays low.
// - Pend irq[5] and irq[1] (mask=0x22) in the same cycle: vec=2 first.
//   After iack, GAP one clk, then vec=6.
// - Pend irq[4] unmasked, then pulse nmi_pin during REQ: vec stays 5 until iack.
//   Next request is vec=0, nmi=1, even with mask=0.
// - Rise on irq[0] in the same cycle as iack for vec 1: pending[1] remains 1 and a new request follows after GAP.
// - Register port: write 0xDEAD_BEEF to table[24] and read it back, with cfg_ready pulsing once per access.
//   Read addr 30 -> 0. Write 0xFFFF_FFFF to pending -> pending reads 0.
// - Assert reset mid-REQ: intrq, vec and handler go to 0 asynchronously, all registers read 0 after reset, and no request until a new edge.

Source files
------------

// File: rtl/hs32_intctl_if.sv
// hs32_intctl_if
// Groups every non-clock signal of the hs32 interrupt controller.
//   irq/nmi_pin          : asynchronous peripheral lines into the controller
//   intrq/handler/vec/nmi: request presented to hs32_cpu; iack is the CPU's acknowledge
//   cfg_*                : register access port
// Register-port handshake: the controller accepts a request at any rising
// edge where cfg_valid=1 and cfg_ready is currently low. It then drives
// cfg_ready=1 for exactly the following cycle, with cfg_dout valid in that cycle.
// cfg_ready is never high in two consecutive cycles. A requester that keeps
// cfg_valid high gets one access every two clocks.
// Modports: master = peripherals/CPU/config side, slave = the controller.
interface hs32_intctl_if;
  logic [23:0] irq;
  logic        nmi_pin;
  logic        intrq;
  logic [31:0] handler;
  logic [4:0]  vec;
  logic        nmi;
  logic        iack;
  logic [4:0]  cfg_addr;
  logic        cfg_rw;
  logic [31:0] cfg_din;
  logic [31:0] cfg_dout;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (
    output irq, nmi_pin, iack, cfg_addr, cfg_rw, cfg_din, cfg_valid,
    input  intrq, handler, vec, nmi, cfg_dout, cfg_ready
  );

  modport slave (
    input  irq, nmi_pin, iack, cfg_addr, cfg_rw, cfg_din, cfg_valid,
    output intrq, handler, vec, nmi, cfg_dout, cfg_ready
  );
endinterface

// File: rtl/hs32_intctl.sv
// hs32_intctl
// Interrupt controller sitting directly in front of hs32_cpu.
// It synchronises 24 IRQ lines and one NMI pin, and latches rising edges into
// the sticky pending register. It picks the lowest eligible index (the NMI is
// index 0) and presents that request, with its ISR address, until the CPU
// acknowledges it.
// Ports:
//   i_clk       : clock
//   reset       : asynchronous, active-high reset
//   bus         : hs32_intctl_if.slave (irq, nmi_pin, CPU request/ack, cfg port)
//   dbg_state_o : current request FSM state (0 idle, 1 req, 2 gap)
// Register map (cfg_addr):
//   0..24 handler table
//   25    mask: bits [23:0] are used, bits [31:24] read as 0
//   26    pending: reads {7'b0, pending}; writing a 1 clears that bit
//   27..31 read as 0; writes are dropped
module hs32_intctl #(
  parameter int NLINES  = 24,
  parameter int SYNC_FF = 2
) (
  input  logic               i_clk,
  input  logic               reset,
  hs32_intctl_if.slave       bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Bit 0 is the NMI. Bits 1..NLINES are the implemented IRQ lines.
  // Bits above NLINES are tied to 0 in the pending register and the mask.
  localparam logic [24:0] LINE_EN = 25'((64'd1 << (NLINES + 1)) - 64'd1);

  localparam logic [4:0] A_MASK = 5'd25;
  localparam logic [4:0] A_PEND = 5'd26;

  state_t                    state_q, state_d;
  logic [SYNC_FF-1:0][24:0]  sync_q;
  logic [24:0]               prev_q;
  logic [24:0]               pending_q, pending_d;
  logic [23:0]               mask_q;
  logic [31:0]               handler_tab_q [25];
  logic                      intrq_q, intrq_d;
  logic [4:0]                vec_q, vec_d;
  logic [31:0]               handler_q, handler_d;
  logic                      nmi_q, nmi_d;
  logic                      cfg_ready_q;
  logic [31:0]               cfg_dout_q;

  logic [24:0]               rise;
  logic [24:0]               eligible;
  logic [4:0]                winner;
  logic                      cfg_acc;
  logic                      cfg_wr;
  logic [24:0]               iack_clr;
  logic [24:0]               w1c_clr;
  logic [31:0]               rd_data;

  // ---------------- edge detection ----------------
  assign rise = sync_q[SYNC_FF-1] & ~prev_q & LINE_EN;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {bus.irq, bus.nmi_pin};
      for (int i = 1; i < SYNC_FF; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  // ---------------- register port ----------------
  // A new access is taken only while cfg_ready is low. This gives the
  // one-cycle cfg_ready pulse and one access per two clocks under a held valid.
  assign cfg_acc = bus.cfg_valid && !cfg_ready_q;
  assign cfg_wr  = cfg_acc && bus.cfg_rw;

  always_comb begin
    rd_data = '0;
    if (bus.cfg_addr <= 5'd24) begin
      rd_data = handler_tab_q[bus.cfg_addr];
    end else if (bus.cfg_addr == A_MASK) begin
      rd_data = {8'd0, mask_q};
    end else if (bus.cfg_addr == A_PEND) begin
      rd_data = {7'd0, pending_q};
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      cfg_dout_q  <= '0;
      mask_q      <= '0;
      for (int i = 0; i < 25; i++) begin
        handler_tab_q[i] <= '0;
      end
    end else begin
      cfg_ready_q <= cfg_acc;
      if (cfg_acc) begin
        cfg_dout_q <= rd_data;
      end
      if (cfg_wr && bus.cfg_addr <= 5'd24) begin
        handler_tab_q[bus.cfg_addr] <= bus.cfg_din;
      end
      if (cfg_wr && bus.cfg_addr == A_MASK) begin
        mask_q <= bus.cfg_din[23:0] & LINE_EN[24:1];
      end
    end
  end

  // ---------------- pending ----------------
  // Clears come from an acknowledge in REQ and from W1C writes. A rise in the
  // same cycle is OR-ed in after the clear, so the new event is kept.
  assign iack_clr = (state_q == S_REQ && bus.iack) ? (25'd1 << vec_q) : '0;
  assign w1c_clr  = (cfg_wr && bus.cfg_addr == A_PEND) ? bus.cfg_din[24:0] : '0;

  always_comb begin
    pending_d = ((pending_q & ~(iack_clr | w1c_clr)) | rise) & LINE_EN;
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // ---------------- arbitration ----------------
  assign eligible = pending_q & {mask_q, 1'b1};

  // Scan from high to low so that the lowest eligible index is left in winner.
  always_comb begin
    winner = '0;
    for (int i = 24; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 5'(i);
      end
    end
  end

  // ---------------- request FSM ----------------
  // The presented vector, handler and nmi flag are captured on entry to REQ.
  // Later table writes, mask changes or higher-priority arrivals cannot
  // disturb the request the CPU is already looking at.
  always_comb begin
    state_d   = state_q;
    intrq_d   = intrq_q;
    vec_d     = vec_q;
    handler_d = handler_q;
    nmi_d     = nmi_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d   = S_REQ;
          intrq_d   = 1'b1;
          vec_d     = winner;
          handler_d = handler_tab_q[winner];
          nmi_d     = (winner == 5'd0);
        end
      end
      S_REQ: begin
        if (bus.iack) begin
          state_d = S_GAP;
          intrq_d = 1'b0;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        intrq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      intrq_q   <= 1'b0;
      vec_q     <= '0;
      handler_q <= '0;
      nmi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intrq_q   <= intrq_d;
      vec_q     <= vec_d;
      handler_q <= handler_d;
      nmi_q     <= nmi_d;
    end
  end

  assign bus.intrq     = intrq_q;
  assign bus.vec       = vec_q;
  assign bus.handler   = handler_q;
  assign bus.nmi       = nmi_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_dout  = cfg_dout_q;
  assign dbg_state_o   = state_q;

endmodule
